// File: rtl/intersect_unit.sv
// intersect_unit: joins the coord/pos streams of two fiber scanners and
// forwards only the coordinates found in both, together with each side's
// position. Stop and done tokens are passed through in step on all three
// outputs.
// Build option: define INTERSECT_DBG_CNT_EN to add match_count/drop_count.

// Small FIFO with wrapping pointers and a separate occupancy counter.
module intersect_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         flush,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop;
    logic          do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A write into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    // The head reads as zero while empty so idle outputs are clean.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (clk_en && !flush && do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clk_en) begin
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) wr_q <= wr_q + 1'b1;
                if (do_pop)  rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
            end
        end
    end
endmodule

module intersect_unit #(
    parameter int                DATA_WIDTH = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH:0] DONE_TOKEN = 17'h10100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                flush,
    input  logic                tile_en,
    input  logic [DATA_WIDTH:0] coord_in_0,
    input  logic                coord_in_0_valid,
    output logic                coord_in_0_ready,
    input  logic [DATA_WIDTH:0] pos_in_0,
    input  logic                pos_in_0_valid,
    output logic                pos_in_0_ready,
    input  logic [DATA_WIDTH:0] coord_in_1,
    input  logic                coord_in_1_valid,
    output logic                coord_in_1_ready,
    input  logic [DATA_WIDTH:0] pos_in_1,
    input  logic                pos_in_1_valid,
    output logic                pos_in_1_ready,
    output logic [DATA_WIDTH:0] coord_out,
    output logic                coord_out_valid,
    input  logic                coord_out_ready,
    output logic [DATA_WIDTH:0] pos_out_0,
    output logic                pos_out_0_valid,
    input  logic                pos_out_0_ready,
    output logic [DATA_WIDTH:0] pos_out_1,
    output logic                pos_out_1_valid,
    input  logic                pos_out_1_ready,
    output logic                protocol_err
`ifdef INTERSECT_DBG_CNT_EN
    ,
    output logic [31:0]         match_count,
    output logic [31:0]         drop_count
`endif
);
    localparam int TW = DATA_WIDTH + 1;

    typedef enum logic {ST_ACTIVE = 1'b0, ST_DONE = 1'b1} state_t;

    // Input channel order: 0 coord A, 1 pos A, 2 coord B, 3 pos B.
    logic [TW-1:0] in_data [4];
    logic [TW-1:0] in_head [4];
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [3:0]    in_push;
    logic [3:0]    in_pop;
    logic [3:0]    in_empty;
    logic [3:0]    in_full;

    // Output channel order: 0 coord, 1 pos A, 2 pos B.
    logic [TW-1:0] out_data [3];
    logic [TW-1:0] out_head [3];
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [2:0]    out_pop;
    logic [2:0]    out_empty;
    logic [2:0]    out_full;

    state_t        state_q;
    logic          err_q;
    logic          decide;
    logic          out_space;
    logic          pop_a;
    logic          pop_b;
    logic          emit;
    logic          data_emit;
    logic          drop;
    logic          set_err;
    logic          go_done;
    logic [TW-1:0] ca, pa, cb, pb;
    logic          a_ctl, b_ctl, a_done, b_done;

    assign in_data[0] = coord_in_0;
    assign in_data[1] = pos_in_0;
    assign in_data[2] = coord_in_1;
    assign in_data[3] = pos_in_1;
    assign in_valid   = {pos_in_1_valid, coord_in_1_valid, pos_in_0_valid, coord_in_0_valid};
    assign coord_in_0_ready = in_ready[0];
    assign pos_in_0_ready   = in_ready[1];
    assign coord_in_1_ready = in_ready[2];
    assign pos_in_1_ready   = in_ready[3];
    assign in_pop = {pop_b, pop_b, pop_a, pop_a};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_in
            assign in_ready[gi] = ~in_full[gi] & tile_en;
            assign in_push[gi]  = in_valid[gi] & in_ready[gi] & clk_en;
            intersect_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .clk_en  (clk_en),
                .flush   (flush),
                .push_i  (in_push[gi]),
                .data_i  (in_data[gi]),
                .pop_i   (in_pop[gi]),
                .data_o  (in_head[gi]),
                .empty_o (in_empty[gi]),
                .full_o  (in_full[gi])
            );
        end
        for (gi = 0; gi < 3; gi++) begin : g_out
            assign out_valid[gi] = ~out_empty[gi] & tile_en;
            assign out_pop[gi]   = out_valid[gi] & out_ready[gi] & clk_en;
            intersect_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .clk_en  (clk_en),
                .flush   (flush),
                .push_i  (emit),
                .data_i  (out_data[gi]),
                .pop_i   (out_pop[gi]),
                .data_o  (out_head[gi]),
                .empty_o (out_empty[gi]),
                .full_o  (out_full[gi])
            );
        end
    endgenerate

    assign out_ready       = {pos_out_1_ready, pos_out_0_ready, coord_out_ready};
    assign coord_out       = out_head[0];
    assign pos_out_0       = out_head[1];
    assign pos_out_1       = out_head[2];
    assign coord_out_valid = out_valid[0];
    assign pos_out_0_valid = out_valid[1];
    assign pos_out_1_valid = out_valid[2];
    assign protocol_err    = err_q;

    assign ca     = in_head[0];
    assign pa     = in_head[1];
    assign cb     = in_head[2];
    assign pb     = in_head[3];
    assign a_ctl  = ca[DATA_WIDTH];
    assign b_ctl  = cb[DATA_WIDTH];
    assign a_done = (ca == DONE_TOKEN);
    assign b_done = (cb == DONE_TOKEN);

    // One decision per cycle, only when both heads are complete.
    assign decide    = clk_en & tile_en & ~flush & (state_q == ST_ACTIVE) & ~(|in_empty);
    // Every output must be able to take a token; a same-cycle pop frees a slot.
    assign out_space = &(~out_full | out_pop);

    // Merge decision: which sides pop and what, if anything, is emitted.
    always_comb begin
        pop_a       = 1'b0;
        pop_b       = 1'b0;
        emit        = 1'b0;
        data_emit   = 1'b0;
        drop        = 1'b0;
        set_err     = 1'b0;
        go_done     = 1'b0;
        out_data[0] = '0;
        out_data[1] = '0;
        out_data[2] = '0;
        if (decide) begin
            if (!a_ctl && !b_ctl) begin
                if (ca[DATA_WIDTH-1:0] == cb[DATA_WIDTH-1:0]) begin
                    if (out_space) begin
                        emit        = 1'b1;
                        data_emit   = 1'b1;
                        pop_a       = 1'b1;
                        pop_b       = 1'b1;
                        out_data[0] = ca;
                        out_data[1] = pa;
                        out_data[2] = pb;
                    end
                end else if (ca[DATA_WIDTH-1:0] < cb[DATA_WIDTH-1:0]) begin
                    pop_a = 1'b1;
                    drop  = 1'b1;
                end else begin
                    pop_b = 1'b1;
                    drop  = 1'b1;
                end
            end else if (!a_ctl) begin
                // B has closed its fiber: drain what remains of A.
                pop_a = 1'b1;
                drop  = 1'b1;
            end else if (!b_ctl) begin
                pop_b = 1'b1;
                drop  = 1'b1;
            end else if (a_done && b_done) begin
                if (out_space) begin
                    emit        = 1'b1;
                    pop_a       = 1'b1;
                    pop_b       = 1'b1;
                    go_done     = 1'b1;
                    out_data[0] = DONE_TOKEN;
                    out_data[1] = DONE_TOKEN;
                    out_data[2] = DONE_TOKEN;
                end
            end else if (a_done || b_done) begin
                // Stop against done: skip the stop so the streams can realign.
                set_err = 1'b1;
                pop_a   = ~a_done;
                pop_b   = ~b_done;
            end else begin
                if (out_space) begin
                    emit        = 1'b1;
                    pop_a       = 1'b1;
                    pop_b       = 1'b1;
                    set_err     = (ca[7:0] != cb[7:0]);
                    out_data[0] = ca;
                    out_data[1] = ca;
                    out_data[2] = ca;
                end
            end
        end
    end

`ifdef INTERSECT_DBG_CNT_EN
    logic [31:0] match_q;
    logic [31:0] drop_q;
    assign match_count = match_q;
    assign drop_count  = drop_q;
`endif

    // Tile FSM, sticky error flag and optional statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACTIVE;
            err_q   <= 1'b0;
`ifdef INTERSECT_DBG_CNT_EN
            match_q <= '0;
            drop_q  <= '0;
`endif
        end else if (clk_en) begin
            if (flush) begin
                state_q <= ST_ACTIVE;
                err_q   <= 1'b0;
`ifdef INTERSECT_DBG_CNT_EN
                match_q <= '0;
                drop_q  <= '0;
`endif
            end else if (tile_en) begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (go_done) state_q <= ST_DONE;
                        if (set_err) err_q <= 1'b1;
`ifdef INTERSECT_DBG_CNT_EN
                        if (data_emit && match_q != 32'hFFFF_FFFF) match_q <= match_q + 32'd1;
                        if (drop && drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
`endif
                    end
                    default: begin
                        state_q <= ST_ACTIVE;
`ifdef INTERSECT_DBG_CNT_EN
                        match_q <= '0;
                        drop_q  <= '0;
`endif
                    end
                endcase
            end
        end
    end

`ifndef INTERSECT_DBG_CNT_EN
    logic unused_dbg;
    assign unused_dbg = data_emit ^ drop;
`endif
endmodule

// File: doc/intersect_unit.md
Name: intersect_unit

Overview:
- Consumes the coord/pos streams of two upstream fiber_access read scanners (A and B) and emits only the coordinates present in both fibers.
- For each matching coordinate it emits the coordinate plus the A and B positions, for downstream value-access/ALU stages.
- Stop and done tokens pass through aligned on all three outputs.
- Stream-based; handles back-to-back tiles without reconfiguration.

Parameters:
DATA_WIDTH, 16, payload width; every token is DATA_WIDTH+1 bits, MSB = control flag
FIFO_DEPTH, 2, entries in each input and output FIFO (power of 2, >=2)
DONE_TOKEN, 17'h10100, done-token encoding

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; low freezes all state
flush  in  1  synchronous clear of FIFOs, FSM and error flag
tile_en  in  1  block enable
coord_in_0 / coord_in_0_valid / coord_in_0_ready  in/in/out  17/1/1  stream A coords
pos_in_0 / pos_in_0_valid / pos_in_0_ready  in/in/out  17/1/1  stream A positions
coord_in_1 / coord_in_1_valid / coord_in_1_ready  in/in/out  17/1/1  stream B coords
pos_in_1 / pos_in_1_valid / pos_in_1_ready  in/in/out  17/1/1  stream B positions
coord_out / coord_out_valid / coord_out_ready  out/out/in  17/1/1  intersected coords
pos_out_0 / pos_out_0_valid / pos_out_0_ready  out/out/in  17/1/1  A positions of matches
pos_out_1 / pos_out_1_valid / pos_out_1_ready  out/out/in  17/1/1  B positions of matches
protocol_err  out  1  sticky token-misalignment flag

Behaviour:
- Token classes:
  - data: bit16=0.
  - done: == DONE_TOKEN.
  - stop: any other token with bit16=1; stop level in [7:0].
- Reset (rst_n low, async):
  - all FIFOs empty, all *_valid=0, all data outputs 0, protocol_err=0, FSM=ACTIVE.
- Inputs:
  - each of the 4 input channels has its own FIFO; *_ready = FIFO not full & tile_en.
  - head A is valid when coord-A and pos-A FIFOs are both non-empty; same for head B.
- Outputs:
  - 3 output FIFOs; *_valid = FIFO non-empty & tile_en.
  - An emit writes all three FIFOs in the same cycle, so it requires all three to have space (pop-same-cycle counts as space).
- Decision, one per cycle when both heads are valid:
  - data/data, ca==cb: emit (ca, pa, pb); pop A and B.
  - data/data, ca<cb (unsigned 16-bit): pop A only. ca>cb: pop B only. Pops need no output space.
  - data/stop or data/done: pop the data side only (drain the remainder of the fiber).
  - stop/stop, equal levels: emit the stop on all three outputs; pop both.
  - stop/stop, unequal levels: set protocol_err; emit A's stop; pop both.
  - done/done: emit DONE_TOKEN on all three outputs; pop both; FSM ACTIVE->DONE for 1 cycle (no pops), then back to ACTIVE for the next tile.
  - stop/done: set protocol_err; pop the stop side only.
- Latency:
  - a token accepted at cycle N reaches its input-FIFO head at N+1.
  - the matching output is valid at N+2.
  - sustained throughput is 1 decision/cycle.
- Empty intersection: only stop/done tokens are emitted; no data.
- clk_en=0 holds all state. Handshakes still show the registered valid, but no transfer is counted.
- flush (sync, when clk_en=1): same state as reset.
- tile_en=0: all ready and valid forced to 0; state held.
- Reset mid-stream discards all buffered tokens; upstream must also be reset.
- FIFO pointers wrap modulo FIFO_DEPTH, with a separate count register; simultaneous push/pop on a full FIFO is allowed.

Optional Feature:
- INTERSECT_DBG_CNT_EN defined: adds outputs match_count[31:0] and drop_count[31:0].
  - match_count increments on each data emit.
  - drop_count increments on each data pop that produces no emit.
  - Both counters clear on reset, on flush, and in the DONE state; they saturate at 32'hFFFFFFFF.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Basic match, all readies held at 1:
  - stimulus: coordA 1,3,5,S0,D; posA 0,1,2,S0,D; coordB 3,4,5,S0,D; posB 10,11,12,S0,D.
  - required: coord_out 3,5,S0,D; pos_out_0 1,2,S0,D; pos_out_1 10,12,S0,D; protocol_err=0.
- Disjoint fibers:
  - stimulus: A 0,2,S0,D; B 1,3,S0,D.
  - required: all outputs S0,D only; no data tokens.
- Back-pressure:
  - stimulus: basic-match vectors with coord_out_ready toggling 1/0 every 3 cycles and pos_out_1_ready randomized.
  - required: identical output sequences; no token lost or duplicated.
- Two tiles back-to-back:
  - stimulus: A 7,S0,D,2,S1,D; B 7,S0,D,2,S1,D.
  - required: outputs 7,S0,D,2,S1,D.
- Misaligned stop levels:
  - stimulus: A S0 vs B S1.
  - required: protocol_err rises the cycle after the decision and stays 1 until flush pulses.
- Async reset mid-stream:
  - stimulus: assert rst_n=0 between clock edges while output FIFOs hold 2 entries.
  - required: all *_valid=0 immediately; after release, the basic-match test passes. Run with INTERSECT_DBG_CNT_EN defined and expect match_count=2, drop_count=2 just before D.
